// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped read-only instruction cache between fetch and memory arbiter
// Hits answer combinationally; a miss is filled by the IDLE/LOAD FSM with fill-data forwarding.
module icache_ctrl #(
  parameter int IIDX_W = 4,
  parameter int ITAG_W = 26
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait,
  output logic [31:0] miss_cnt
);

  localparam int NFRAMES = 1 << IIDX_W;

  typedef enum logic {IDLE, LOAD} istate_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [31:0]       data;
  } icache_block;

  icache_block        frames [NFRAMES];
  istate_t            state;
  logic [31:0]        fill_addr;
  logic [31:0]        miss_q;
  logic               iren_q;

  logic [IIDX_W-1:0]  lookup_idx;
  logic [ITAG_W-1:0]  lookup_tag;
  logic [IIDX_W-1:0]  fill_idx;
  logic [ITAG_W-1:0]  fill_tag;
  logic               lookup_hit;
  logic               fill_done;

  assign lookup_idx = imemaddr[IIDX_W+1:2];
  assign lookup_tag = imemaddr[31:IIDX_W+2];
  assign fill_idx   = fill_addr[IIDX_W+1:2];
  assign fill_tag   = fill_addr[31:IIDX_W+2];

  assign lookup_hit = imemREN && frames[lookup_idx].valid &&
                      (frames[lookup_idx].tag == lookup_tag);
  assign fill_done  = (state == LOAD) && !iwait;

  assign iREN     = iren_q;
  assign iaddr    = fill_addr;
  assign miss_cnt = miss_q;

  // During LOAD only the exact fill address may be forwarded, and only on the data cycle.
  always_comb begin
    ihit     = 1'b0;
    imemload = 32'h0;
    if (state == IDLE) begin
      if (lookup_hit) begin
        ihit     = 1'b1;
        imemload = frames[lookup_idx].data;
      end
    end else if (fill_done && imemREN && (imemaddr == fill_addr)) begin
      ihit     = 1'b1;
      imemload = iload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NFRAMES; i++) begin
        frames[i] <= '0;
      end
      state     <= IDLE;
      fill_addr <= 32'h0;
      miss_q    <= 32'h0;
      iren_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !lookup_hit) begin
            fill_addr <= imemaddr;
            iren_q    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          // The arbiter has no cancel, so the fill always completes and installs.
          if (!iwait) begin
            frames[fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: iload};
            miss_q           <= miss_q + 32'd1;
            iren_q           <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - scoreboard bench for icache_ctrl
module tb_icache_ctrl;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [31:0] miss_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  sb_entry_t   sb [$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          fails  = 0;
  int          exp_miss = 0;

  icache_ctrl #(.IIDX_W(4), .ITAG_W(26)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .imemload(imemload), .ihit(ihit), .iREN(iREN), .iaddr(iaddr),
    .iload(iload), .iwait(iwait), .miss_cnt(miss_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hA000_0000 | a;
  endfunction

  // Called on a cycle where ihit is 1: pop the expected entry and compare.
  task automatic sb_pop(input string name);
    sb_entry_t e;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s sb_empty: ihit with imemaddr=%h, no expectation queued", name, imemaddr);
    end else begin
      e = sb.pop_front();
      if (imemload !== e.data || imemaddr !== e.addr) begin
        fails++;
        $display("FAIL %s sb_data: addr=%h imemload=%h, required addr=%h data=%h",
                 name, imemaddr, imemload, e.addr, e.data);
      end
    end
  endtask

  // Starts and ends just after a rising edge with the FSM in IDLE.
  task automatic fetch(input logic [31:0] a, input bit exp_hit, input int waits);
    sb_entry_t e;
    e.addr = a;
    e.data = mem_word(a);
    sb.push_back(e);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    iload    = 32'hDEAD_BEEF;
    @(negedge CLK);
    checks++;
    if (ihit !== exp_hit || iREN !== 1'b0) begin
      fails++;
      $display("FAIL fetch_lookup %h: ihit=%b iREN=%b, required ihit=%b iREN=0", a, ihit, iREN, exp_hit);
    end
    if (ihit === 1'b1) sb_pop("fetch_hit");
    @(posedge CLK); #1;
    if (exp_hit) begin
      imemREN = 1'b0;
      checks++;
      if (miss_cnt !== 32'(exp_miss)) begin
        fails++;
        $display("FAIL hit_miss_cnt %h: miss_cnt=%0d, required %0d", a, miss_cnt, exp_miss);
      end
      return;
    end
    for (int k = 0; k < waits; k++) begin
      @(negedge CLK);
      checks++;
      if (iREN !== 1'b1 || iaddr !== a || ihit !== 1'b0) begin
        fails++;
        $display("FAIL load_wait %h: iREN=%b iaddr=%h ihit=%b, required 1/%h/0", a, iREN, iaddr, ihit, a);
      end
      @(posedge CLK); #1;
    end
    iwait = 1'b0;
    iload = mem_word(a);
    @(negedge CLK);
    checks++;
    if (ihit !== 1'b1 || iREN !== 1'b1 || iaddr !== a) begin
      fails++;
      $display("FAIL load_done %h: ihit=%b iREN=%b iaddr=%h, required 1/1/%h", a, ihit, iREN, iaddr, a);
    end
    if (ihit === 1'b1) sb_pop("fill_forward");
    @(posedge CLK); #1;
    iwait   = 1'b1;
    imemREN = 1'b0;
    exp_miss++;
    checks++;
    if (iREN !== 1'b0 || miss_cnt !== 32'(exp_miss)) begin
      fails++;
      $display("FAIL after_fill %h: iREN=%b miss_cnt=%0d, required 0/%0d", a, iREN, miss_cnt, exp_miss);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s sb_leftover: %0d entries, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; iload = 32'h0;
    #1 nRST = 1'b0;
    #1;
    checks++;
    if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0 || miss_cnt !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: ihit=%b iREN=%b iaddr=%h imemload=%h miss_cnt=%0d, required all 0",
               ihit, iREN, iaddr, imemload, miss_cnt);
    end
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    imemREN = 1'b0;
    nRST = 1'b1;
    exp_miss = 0;
  endtask

  task automatic test_first_miss_and_hit;
    fetch(32'h40, 1'b0, 3);
    fetch(32'h40, 1'b1, 0);
    check_sb_empty("first_miss_hit");
  endtask

  task automatic test_conflict;
    fetch(32'h440, 1'b0, 2);
    fetch(32'h440, 1'b1, 0);
    fetch(32'h40, 1'b0, 0);
    fetch(32'h40, 1'b1, 0);
    check_sb_empty("conflict");
  endtask

  task automatic test_squash;
    imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;
    imemaddr = 32'h100;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      checks++;
      if (ihit !== 1'b0 || iaddr !== 32'h80 || iREN !== 1'b1) begin
        fails++;
        $display("FAIL squash_wait: ihit=%b iaddr=%h iREN=%b, required 0/00000080/1", ihit, iaddr, iREN);
      end
      @(posedge CLK); #1;
    end
    iwait = 1'b0;
    iload = mem_word(32'h80);
    @(negedge CLK);
    checks++;
    if (ihit !== 1'b0) begin
      fails++;
      $display("FAIL squash_done_ihit: ihit=%b, required 0", ihit);
    end
    @(posedge CLK); #1;
    iwait = 1'b1; imemREN = 1'b0;
    exp_miss++;
    fetch(32'h80, 1'b1, 0);
    fetch(32'h100, 1'b0, 1);
    check_sb_empty("squash");
  endtask

  task automatic test_reset_mid_load;
    imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (iREN !== 1'b1) begin
      fails++;
      $display("FAIL midload_pre: iREN=%b, required 1", iREN);
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (iREN !== 1'b0 || ihit !== 1'b0 || miss_cnt !== 32'h0) begin
      fails++;
      $display("FAIL midload_reset: iREN=%b ihit=%b miss_cnt=%0d, required 0/0/0", iREN, ihit, miss_cnt);
    end
    @(posedge CLK); #1;
    imemREN = 1'b0;
    nRST = 1'b1;
    exp_miss = 0;
    fetch(32'h40, 1'b0, 1);
    check_sb_empty("reset_mid_load");
  endtask

  task automatic test_fill_all;
    sb_entry_t e;
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    exp_miss = 0;
    for (int i = 0; i < 16; i++) fetch(32'(i * 4), 1'b0, i % 3);
    for (int i = 0; i < 16; i++) begin
      imemREN  = 1'b1;
      imemaddr = 32'(i * 4);
      e.addr = imemaddr;
      e.data = mem_word(imemaddr);
      sb.push_back(e);
      @(negedge CLK);
      checks++;
      if (ihit !== 1'b1 || iREN !== 1'b0) begin
        fails++;
        $display("FAIL burst_hit %h: ihit=%b iREN=%b, required 1/0", imemaddr, ihit, iREN);
      end
      if (ihit === 1'b1) sb_pop("burst");
      @(posedge CLK); #1;
    end
    imemREN = 1'b0;
    checks++;
    if (miss_cnt !== 32'd16) begin
      fails++;
      $display("FAIL fill_all_miss_cnt: miss_cnt=%0d, required 16", miss_cnt);
    end
    check_sb_empty("fill_all");
  endtask

  initial begin
    mem[32'h40]  = 32'h8C01_0004;
    mem[32'h440] = 32'h2002_0005;
    mem[32'h80]  = 32'h1111_0080;
    mem[32'h100] = 32'h2222_0100;
    mem[32'h200] = 32'h3333_0200;
    test_reset;
    test_first_miss_and_hit;
    test_conflict;
    test_squash;
    test_reset_mid_load;
    test_fill_all;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
